// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encoding and default datapath widths.
// The controller's decode uses the same opcode encoding.
package cpu_pkg;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_D_ADDR_W = 8;
  localparam int DEF_R_ADDR_W = 4;

  typedef enum logic [3:0] {
    ALU_ZERO = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_PASS = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_INC  = 4'd7,
    ALU_SHL  = 4'd8,
    ALU_SHR  = 4'd9,
    ALU_NOT  = 4'd10
  } alu_op_t;
endpackage

// File: rtl/datapath_unit_regfile.sv
// Register file: two combinational read ports and one synchronous write port.
// There is no write-to-read bypass; a written value appears from the next cycle.
module regfile
  import cpu_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int R_ADDR_W = DEF_R_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [R_ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [R_ADDR_W-1:0] raddr_a,
  input  logic [R_ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]    rdata_a,
  output logic [WIDTH-1:0]    rdata_b
);
  logic [WIDTH-1:0] mem [2**R_ADDR_W];

  // Reset takes priority, so a write strobe in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**R_ADDR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/datapath_unit.sv
// Execution datapath of the multicycle CPU: register file, ALU and data RAM,
// driven each cycle by the instruction controller's decoded strobes.
module datapath_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int D_ADDR_W = DEF_D_ADDR_W,
  parameter int R_ADDR_W = DEF_R_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                D_wr,
  input  logic                RF_s,
  input  logic                RF_W_en,
  input  logic [D_ADDR_W-1:0] D_addr,
  input  logic [R_ADDR_W-1:0] RF_W_addr,
  input  logic [R_ADDR_W-1:0] RF_A_addr,
  input  logic [R_ADDR_W-1:0] RF_B_addr,
  input  logic [3:0]          ALU_sel,
  output logic [WIDTH-1:0]    ALU_A_Out,
  output logic [WIDTH-1:0]    ALU_B_Out,
  output logic [WIDTH-1:0]    ALU_Out,
  output logic [WIDTH-1:0]    D_rdata_Out
);
  logic [WIDTH-1:0] ram [2**D_ADDR_W];
  logic [WIDTH-1:0] d_rdata;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] a, b, y;

  assign rf_wdata = RF_s ? d_rdata : y;

  regfile #(.WIDTH(WIDTH), .R_ADDR_W(R_ADDR_W)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (RF_W_en),
    .waddr   (RF_W_addr),
    .wdata   (rf_wdata),
    .raddr_a (RF_A_addr),
    .raddr_b (RF_B_addr),
    .rdata_a (a),
    .rdata_b (b)
  );

  // Arithmetic wraps modulo 2**WIDTH; unused opcodes yield zero.
  always_comb begin
    y = '0;
    case (alu_op_t'(ALU_sel))
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_PASS: y = a;
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_INC:  y = a + WIDTH'(1);
      ALU_SHL:  y = {a[WIDTH-2:0], 1'b0};
      ALU_SHR:  y = {1'b0, a[WIDTH-1:1]};
      ALU_NOT:  y = ~a;
      default:  y = '0;
    endcase
  end

  // Write port kept free of reset logic so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (D_wr && !reset) ram[D_addr] <= a;
  end

  // Registered read returns old data on a same-address write.
  always_ff @(posedge clk) begin
    if (reset) d_rdata <= '0;
    else       d_rdata <= ram[D_addr];
  end

  assign ALU_A_Out   = a;
  assign ALU_B_Out   = b;
  assign ALU_Out     = y;
  assign D_rdata_Out = d_rdata;
endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: ALU vector table, RAM read scoreboard,
// and hand-written load/store, read-during-write and reset-mid-load sequences.
module tb_datapath_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel;
  logic [15:0] ALU_A_Out, ALU_B_Out, ALU_Out, D_rdata_Out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        known;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  a_addr;
    logic [3:0]  b_addr;
    logic [3:0]  sel;
    logic [15:0] exp_y;
  } vec_t;

  exp_t        exp_q[$];
  logic [15:0] rf_m [16];
  logic [15:0] ram_m [int];
  logic [15:0] drd_m;
  vec_t        vecs [22];

  always #5 clk = ~clk;

  datapath_unit dut (
    .clk         (clk),
    .reset       (reset),
    .D_wr        (D_wr),
    .RF_s        (RF_s),
    .RF_W_en     (RF_W_en),
    .D_addr      (D_addr),
    .RF_W_addr   (RF_W_addr),
    .RF_A_addr   (RF_A_addr),
    .RF_B_addr   (RF_B_addr),
    .ALU_sel     (ALU_sel),
    .ALU_A_Out   (ALU_A_Out),
    .ALU_B_Out   (ALU_B_Out),
    .ALU_Out     (ALU_Out),
    .D_rdata_Out (D_rdata_Out)
  );

  function automatic logic [15:0] alu_f(input logic [3:0] s, input logic [15:0] x, input logic [15:0] z);
    case (s)
      4'd1:    return x + z;
      4'd2:    return x - z;
      4'd3:    return x;
      4'd4:    return x ^ z;
      4'd5:    return x | z;
      4'd6:    return x & z;
      4'd7:    return x + 16'd1;
      4'd8:    return {x[14:0], 1'b0};
      4'd9:    return {1'b0, x[15:1]};
      4'd10:   return ~x;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare the combinational outputs against the bench's register-file model.
  task automatic chk_comb(input string name);
    #1;
    chk({name, "_a"}, ALU_A_Out, rf_m[RF_A_addr]);
    chk({name, "_b"}, ALU_B_Out, rf_m[RF_B_addr]);
    chk({name, "_y"}, ALU_Out, alu_f(ALU_sel, rf_m[RF_A_addr], rf_m[RF_B_addr]));
  endtask

  // One clock: predict the RAM read and model updates, then compare after the edge.
  task automatic step();
    exp_t        e;
    int          da;
    logic        rst, we, rw;
    logic [3:0]  wa;
    logic [15:0] wv, av;
    da  = int'(D_addr);
    rst = reset;
    e.known = rst || ram_m.exists(da);
    e.data  = rst ? 16'h0000 : (ram_m.exists(da) ? ram_m[da] : 16'h0000);
    exp_q.push_back(e);
    we = RF_W_en && !rst;
    wa = RF_W_addr;
    wv = RF_s ? drd_m : alu_f(ALU_sel, rf_m[RF_A_addr], rf_m[RF_B_addr]);
    rw = D_wr && !rst;
    av = rf_m[RF_A_addr];
    @(posedge clk);
    #1;
    if (rw) ram_m[da] = av;
    if (we) rf_m[wa] = wv;
    if (rst) for (int i = 0; i < 16; i++) rf_m[i] = 16'h0000;
    e = exp_q.pop_front();
    if (e.known) chk("d_rdata", D_rdata_Out, e.data);
    drd_m = e.data;
  endtask

  task automatic idle();
    D_wr = 0; RF_s = 0; RF_W_en = 0;
    D_addr = 8'h00; RF_W_addr = 0; RF_A_addr = 0; RF_B_addr = 0; ALU_sel = 0;
  endtask

  // Build a register value through the ALU path: clear, then shift/increment per bit.
  task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
    idle();
    RF_A_addr = r; RF_W_addr = r; RF_W_en = 1; ALU_sel = 4'd0;
    step();
    for (int bit_i = 15; bit_i >= 0; bit_i--) begin
      ALU_sel = 4'd8;
      step();
      if (v[bit_i]) begin
        ALU_sel = 4'd7;
        step();
      end
    end
    idle();
    RF_A_addr = r;
    #1;
    chk("set_reg", ALU_A_Out, v);
  endtask

  initial begin
    vecs[0]  = '{4'd15, 4'd14, 4'd1,  16'h0000};
    vecs[1]  = '{4'd15, 4'd14, 4'd2,  16'hFFFE};
    vecs[2]  = '{4'd15, 4'd14, 4'd3,  16'hFFFF};
    vecs[3]  = '{4'd15, 4'd14, 4'd4,  16'hFFFE};
    vecs[4]  = '{4'd15, 4'd14, 4'd5,  16'hFFFF};
    vecs[5]  = '{4'd15, 4'd14, 4'd6,  16'h0001};
    vecs[6]  = '{4'd15, 4'd14, 4'd7,  16'h0000};
    vecs[7]  = '{4'd15, 4'd14, 4'd8,  16'hFFFE};
    vecs[8]  = '{4'd15, 4'd14, 4'd9,  16'h7FFF};
    vecs[9]  = '{4'd15, 4'd14, 4'd10, 16'h0000};
    vecs[10] = '{4'd15, 4'd14, 4'd11, 16'h0000};
    vecs[11] = '{4'd15, 4'd14, 4'd12, 16'h0000};
    vecs[12] = '{4'd15, 4'd14, 4'd15, 16'h0000};
    vecs[13] = '{4'd15, 4'd14, 4'd0,  16'h0000};
    vecs[14] = '{4'd1,  4'd15, 4'd1,  16'h1233};
    vecs[15] = '{4'd1,  4'd15, 4'd2,  16'h1235};
    vecs[16] = '{4'd1,  4'd15, 4'd4,  16'hEDCB};
    vecs[17] = '{4'd1,  4'd15, 4'd5,  16'hFFFF};
    vecs[18] = '{4'd1,  4'd15, 4'd6,  16'h1234};
    vecs[19] = '{4'd1,  4'd15, 4'd8,  16'h2468};
    vecs[20] = '{4'd1,  4'd15, 4'd9,  16'h091A};
    vecs[21] = '{4'd1,  4'd15, 4'd10, 16'hEDCB};

    idle();
    reset = 1;
    step();
    step();
    reset = 0;

    // Reset state
    ALU_sel = 4'd7; RF_A_addr = 4'd3;
    #1;
    chk("rst_alu_a", ALU_A_Out, 16'h0000);
    chk("rst_alu_b", ALU_B_Out, 16'h0000);
    chk("rst_alu_y", ALU_Out, 16'h0001);
    chk("rst_drdata", D_rdata_Out, 16'h0000);

    set_reg(4'd1, 16'h1234);
    set_reg(4'd15, 16'hFFFF);
    set_reg(4'd14, 16'h0001);
    set_reg(4'd2, 16'h00FF);

    foreach (vecs[i]) begin
      RF_A_addr = vecs[i].a_addr; RF_B_addr = vecs[i].b_addr; ALU_sel = vecs[i].sel;
      #1;
      chk($sformatf("alu_vec%0d", i), ALU_Out, vecs[i].exp_y);
      chk_comb($sformatf("alu_model%0d", i));
    end

    // Store RF[1] to RAM[0x20], then read it back
    idle();
    D_addr = 8'h20; RF_A_addr = 4'd1; D_wr = 1;
    step();
    D_wr = 0;
    step();
    chk("store_readback", D_rdata_Out, 16'h1234);

    // Load RAM[0x20] into RF[5]: address cycle N, writeback cycle N+1
    idle();
    D_addr = 8'h20;
    step();
    RF_s = 1; RF_W_en = 1; RF_W_addr = 4'd5; RF_A_addr = 4'd5;
    #1;
    chk("load_old", ALU_A_Out, 16'h0000);
    step();
    RF_s = 0; RF_W_en = 0;
    #1;
    chk("load_new", ALU_A_Out, 16'h1234);

    // Same-cycle RF write and read of RF[2]
    idle();
    RF_A_addr = 4'd2; RF_W_addr = 4'd2; RF_W_en = 1; ALU_sel = 4'd7;
    #1;
    chk("rf_rdw_old", ALU_A_Out, 16'h00FF);
    step();
    RF_W_en = 0;
    #1;
    chk("rf_rdw_new", ALU_A_Out, 16'h0100);
    chk_comb("rf_rdw");

    // RAM write and read of 0x20 on the same edge returns the old word
    D_addr = 8'h20; D_wr = 1;
    step();
    chk("ram_rdw_old", D_rdata_Out, 16'h1234);
    D_wr = 0;
    step();
    chk("ram_rdw_new", D_rdata_Out, 16'h0100);

    // Restore RAM[0x20] = 0x1234 from RF[1]
    RF_A_addr = 4'd1; D_wr = 1;
    step();
    D_wr = 0;

    // Reset asserted in load cycle N+1, with a competing RAM write
    idle();
    D_addr = 8'h20;
    step();
    reset = 1; RF_s = 1; RF_W_en = 1; RF_W_addr = 4'd5; D_wr = 1; RF_A_addr = 4'd15;
    step();
    reset = 0;
    idle();
    D_addr = 8'h20; RF_A_addr = 4'd5;
    #1;
    chk("rstload_rf5", ALU_A_Out, 16'h0000);
    chk("rstload_drd", D_rdata_Out, 16'h0000);
    step();
    chk("rstload_ram", D_rdata_Out, 16'h1234);
    chk_comb("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
